// File: rtl/host_cmd_seq.sv
// Host command sequencer: frames a register/ALU request into UART bytes,
// then collects the 1- or 2-byte reply (LSB first) or reports a timeout.
module host_cmd_seq #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADD         = 4,
   parameter int FUNC        = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    REQ_VLD,
   output logic                    REQ_RDY,
   input  logic [1:0]              REQ_CMD,
   input  logic [ADD-1:0]          REQ_ADDR,
   input  logic [DATA_WIDTH-1:0]   REQ_DATA,
   input  logic [DATA_WIDTH-1:0]   REQ_OP_A,
   input  logic [DATA_WIDTH-1:0]   REQ_OP_B,
   input  logic [FUNC-1:0]         REQ_FUNC,
   output logic [DATA_WIDTH-1:0]   TX_P_Data,
   output logic                    TX_D_VLD,
   input  logic                    TX_BUSY,
   input  logic [DATA_WIDTH-1:0]   RX_P_Data,
   input  logic                    RX_D_VLD,
   output logic [2*DATA_WIDTH-1:0] RSP_DATA,
   output logic                    RSP_VLD,
   output logic                    RSP_ERR
);

   localparam int CW = $clog2(TIMEOUT_CYC);
   // The counter "reaches" TIMEOUT_CYC-1 on the edge where it would step past this value.
   localparam logic [CW-1:0] EXPIRE = CW'(TIMEOUT_CYC - 2);

   localparam logic [1:0] CMD_WR   = 2'b00;
   localparam logic [1:0] CMD_RD   = 2'b01;
   localparam logic [1:0] CMD_ALU  = 2'b10;
   localparam logic [1:0] CMD_ALUN = 2'b11;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

   state_t                  state_q;
   logic [1:0]              cmd_q;
   logic [ADD-1:0]          addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [DATA_WIDTH-1:0]   opa_q;
   logic [DATA_WIDTH-1:0]   opb_q;
   logic [FUNC-1:0]         func_q;
   logic [1:0]              tx_idx_q;
   logic [DATA_WIDTH-1:0]   tx_data_q;
   logic                    tx_vld_q;
   logic                    rx_idx_q;
   logic [2*DATA_WIDTH-1:0] rx_buf_q;
   logic [CW-1:0]           cnt_q;
   logic [2*DATA_WIDTH-1:0] rsp_data_q;
   logic                    rsp_vld_q;
   logic                    rsp_err_q;
   logic                    rdy_q;

   logic [DATA_WIDTH-1:0]   next_byte_d;
   logic [2*DATA_WIDTH-1:0] rx_word_d;
   logic                    rx_last_d;

   function automatic logic [DATA_WIDTH-1:0] frame_byte(
      input logic [1:0]            cmd,
      input logic [1:0]            idx,
      input logic [ADD-1:0]        addr,
      input logic [DATA_WIDTH-1:0] data,
      input logic [DATA_WIDTH-1:0] op_a,
      input logic [DATA_WIDTH-1:0] op_b,
      input logic [FUNC-1:0]       func
   );
      case (cmd)
         CMD_WR: begin
            case (idx)
               2'd0:    return DATA_WIDTH'(8'hAA);
               2'd1:    return DATA_WIDTH'(addr);
               default: return data;
            endcase
         end
         CMD_RD: begin
            case (idx)
               2'd0:    return DATA_WIDTH'(8'hBB);
               default: return DATA_WIDTH'(addr);
            endcase
         end
         CMD_ALU: begin
            case (idx)
               2'd0:    return DATA_WIDTH'(8'hCC);
               2'd1:    return op_a;
               2'd2:    return op_b;
               default: return DATA_WIDTH'(func);
            endcase
         end
         default: begin
            case (idx)
               2'd0:    return DATA_WIDTH'(8'hDD);
               default: return DATA_WIDTH'(func);
            endcase
         end
      endcase
   endfunction

   function automatic logic [1:0] frame_last(input logic [1:0] cmd);
      case (cmd)
         CMD_WR:  return 2'd2;
         CMD_RD:  return 2'd1;
         CMD_ALU: return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   // Next outgoing byte and the reply word as it would look with the current RX byte merged in.
   always_comb begin
      next_byte_d = frame_byte(cmd_q, tx_idx_q + 2'd1, addr_q, data_q, opa_q, opb_q, func_q);
      rx_last_d   = (cmd_q == CMD_RD) ? 1'b0 : 1'b1;
      rx_word_d   = rx_buf_q;
      if (rx_idx_q == 1'b0) begin
         rx_word_d[DATA_WIDTH-1:0] = RX_P_Data;
      end else begin
         rx_word_d[2*DATA_WIDTH-1:DATA_WIDTH] = RX_P_Data;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         cmd_q      <= 2'b00;
         addr_q     <= '0;
         data_q     <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         func_q     <= '0;
         tx_idx_q   <= 2'd0;
         tx_data_q  <= '0;
         tx_vld_q   <= 1'b0;
         rx_idx_q   <= 1'b0;
         rx_buf_q   <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_err_q  <= 1'b0;
         rdy_q      <= 1'b1;
      end else begin
         rsp_vld_q <= 1'b0;
         rsp_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (REQ_VLD && rdy_q) begin
                  cmd_q     <= REQ_CMD;
                  addr_q    <= REQ_ADDR;
                  data_q    <= REQ_DATA;
                  opa_q     <= REQ_OP_A;
                  opb_q     <= REQ_OP_B;
                  func_q    <= REQ_FUNC;
                  tx_idx_q  <= 2'd0;
                  tx_data_q <= frame_byte(REQ_CMD, 2'd0, REQ_ADDR, REQ_DATA, REQ_OP_A, REQ_OP_B, REQ_FUNC);
                  tx_vld_q  <= 1'b1;
                  rx_idx_q  <= 1'b0;
                  rx_buf_q  <= '0;
                  cnt_q     <= '0;
                  rdy_q     <= 1'b0;
                  state_q   <= SEND;
               end
            end
            SEND: begin
               if (tx_vld_q && !TX_BUSY) begin
                  if (tx_idx_q == frame_last(cmd_q)) begin
                     tx_vld_q <= 1'b0;
                     cnt_q    <= '0;
                     if (cmd_q == CMD_WR) begin
                        rsp_data_q <= '0;
                        rsp_vld_q  <= 1'b1;
                        state_q    <= DONE;
                     end else begin
                        state_q <= WAIT_RSP;
                     end
                  end else begin
                     tx_idx_q  <= tx_idx_q + 2'd1;
                     tx_data_q <= next_byte_d;
                  end
               end
            end
            WAIT_RSP: begin
               // A byte landing on the expiry cycle takes priority over the timeout.
               if (RX_D_VLD) begin
                  rx_buf_q <= rx_word_d;
                  cnt_q    <= '0;
                  if (rx_idx_q == rx_last_d) begin
                     rsp_data_q <= rx_word_d;
                     rsp_vld_q  <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     rx_idx_q <= 1'b1;
                  end
               end else if (cnt_q == EXPIRE) begin
                  rsp_data_q <= rx_buf_q;
                  rsp_err_q  <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               rdy_q   <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               tx_vld_q <= 1'b0;
               rdy_q    <= 1'b1;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign REQ_RDY   = rdy_q;
   assign TX_P_Data = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign RSP_DATA  = rsp_data_q;
   assign RSP_VLD   = rsp_vld_q;
   assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_host_cmd_seq.sv
// Bench for host_cmd_seq: vector table of requests with expected frames and
// replies, scoreboard queues checked by a negedge monitor, plus reset/stray cases.
module tb_host_cmd_seq;
   localparam int TO = 16;

   logic        CLK;
   logic        RST;
   logic        REQ_VLD;
   logic        REQ_RDY;
   logic [1:0]  REQ_CMD;
   logic [3:0]  REQ_ADDR;
   logic [7:0]  REQ_DATA;
   logic [7:0]  REQ_OP_A;
   logic [7:0]  REQ_OP_B;
   logic [3:0]  REQ_FUNC;
   logic [7:0]  TX_P_Data;
   logic        TX_D_VLD;
   logic        TX_BUSY;
   logic [7:0]  RX_P_Data;
   logic        RX_D_VLD;
   logic [15:0] RSP_DATA;
   logic        RSP_VLD;
   logic        RSP_ERR;

   host_cmd_seq #(.DATA_WIDTH(8), .ADD(4), .FUNC(4), .TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_CMD(REQ_CMD), .REQ_ADDR(REQ_ADDR),
      .REQ_DATA(REQ_DATA), .REQ_OP_A(REQ_OP_A), .REQ_OP_B(REQ_OP_B), .REQ_FUNC(REQ_FUNC),
      .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
      .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
      .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .RSP_ERR(RSP_ERR)
   );

   typedef struct {
      logic [1:0]  cmd;
      logic [3:0]  addr;
      logic [7:0]  data;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  func;
      int          busy_byte;
      int          busy_cyc;
      logic        stray;
      int          nrx;
      logic [7:0]  rx0;
      logic [7:0]  rx1;
      int          gap0;
      int          gap1;
      int          flen;
      logic [31:0] frame;
      logic [15:0] exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t        vecs[12];
   logic [7:0]  exp_tx_q[$];
   logic [16:0] exp_rsp_q[$];
   logic [7:0]  mon_b;
   logic [16:0] mon_r;
   logic [15:0] last_rsp;
   int          checks;
   int          errors;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every transferred byte and every response pulse must match the queue head.
   always @(negedge CLK) begin
      if (RST) begin
         if (TX_D_VLD && !TX_BUSY) begin
            if (exp_tx_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_extra act=%h exp=none", TX_P_Data);
            end else begin
               mon_b = exp_tx_q.pop_front();
               chk("tx_byte", {24'd0, TX_P_Data}, {24'd0, mon_b});
            end
         end
         if (RSP_VLD || RSP_ERR) begin
            if (exp_rsp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_extra act=%h/%b/%b exp=none", RSP_DATA, RSP_VLD, RSP_ERR);
            end else begin
               mon_r = exp_rsp_q.pop_front();
               chk("rsp_data", {16'd0, RSP_DATA}, {16'd0, mon_r[15:0]});
               chk("rsp_err", {31'd0, RSP_ERR}, {31'd0, mon_r[16]});
               chk("rsp_vld", {31'd0, RSP_VLD}, {31'd0, ~mon_r[16]});
            end
         end
      end
   end

   task automatic run_txn(input vec_t v);
      int n;
      n = 0;
      @(negedge CLK);
      while (!REQ_RDY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("req_rdy", {31'd0, REQ_RDY}, 32'd1);
      REQ_VLD  = 1'b1;
      REQ_CMD  = v.cmd;
      REQ_ADDR = v.addr;
      REQ_DATA = v.data;
      REQ_OP_A = v.a;
      REQ_OP_B = v.b;
      REQ_FUNC = v.func;
      for (int k = 0; k < v.flen; k++) exp_tx_q.push_back(v.frame[31-8*k -: 8]);
      exp_rsp_q.push_back({v.exp_err, v.exp_data});
      @(posedge CLK);
      #1;
      REQ_VLD  = 1'b0;
      REQ_CMD  = 2'($urandom);
      REQ_ADDR = 4'($urandom);
      REQ_DATA = 8'($urandom);
      REQ_OP_A = 8'($urandom);
      REQ_OP_B = 8'($urandom);
      REQ_FUNC = 4'($urandom);
      for (int k = 0; k < v.flen; k++) begin
         if (k == 0 && v.stray) begin
            RX_D_VLD  = 1'b1;
            RX_P_Data = 8'hEE;
         end
         if (k == v.busy_byte) begin
            TX_BUSY = 1'b1;
            for (int j = 0; j < v.busy_cyc; j++) begin
               @(negedge CLK);
               chk("busy_vld", {31'd0, TX_D_VLD}, 32'd1);
               chk("busy_hold", {24'd0, TX_P_Data}, {24'd0, v.frame[31-8*k -: 8]});
               @(posedge CLK);
               #1;
               RX_D_VLD = 1'b0;
            end
            TX_BUSY = 1'b0;
         end
         @(negedge CLK);
         chk("tx_b2b", {31'd0, TX_D_VLD}, 32'd1);
         if (k == 0) chk("rsp_hold_prev", {16'd0, RSP_DATA}, {16'd0, last_rsp});
         @(posedge CLK);
         #1;
         RX_D_VLD = 1'b0;
      end
      for (int i = 0; i < v.nrx; i++) begin
         repeat ((i == 0) ? v.gap0 : v.gap1) begin
            @(posedge CLK);
            #1;
         end
         RX_D_VLD  = 1'b1;
         RX_P_Data = (i == 0) ? v.rx0 : v.rx1;
         @(posedge CLK);
         #1;
         RX_D_VLD  = 1'b0;
         RX_P_Data = 8'($urandom);
      end
      n = 0;
      forever begin
         @(negedge CLK);
         if (RSP_VLD || RSP_ERR) break;
         if (n >= TO + 4) break;
         @(posedge CLK);
         #1;
         n++;
      end
      chk("rsp_latency", n, v.exp_lat);
      chk("tx_quiet", {31'd0, TX_D_VLD}, 32'd0);
      chk("rdy_done", {31'd0, REQ_RDY}, 32'd0);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("rdy_after", {31'd0, REQ_RDY}, 32'd1);
      chk("pulse_one", {31'd0, RSP_VLD | RSP_ERR}, 32'd0);
      chk("rsp_hold", {16'd0, RSP_DATA}, {16'd0, v.exp_data});
      last_rsp = v.exp_data;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdy"}, {31'd0, REQ_RDY}, 32'd1);
      chk({tag, "_txv"}, {31'd0, TX_D_VLD}, 32'd0);
      chk({tag, "_txd"}, {24'd0, TX_P_Data}, 32'd0);
      chk({tag, "_rspd"}, {16'd0, RSP_DATA}, 32'd0);
      chk({tag, "_rspv"}, {31'd0, RSP_VLD}, 32'd0);
      chk({tag, "_rspe"}, {31'd0, RSP_ERR}, 32'd0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      last_rsp  = 16'h0000;
      RST       = 1'b0;
      REQ_VLD   = 1'b0;
      REQ_CMD   = 2'b00;
      REQ_ADDR  = 4'h0;
      REQ_DATA  = 8'h00;
      REQ_OP_A  = 8'h00;
      REQ_OP_B  = 8'h00;
      REQ_FUNC  = 4'h0;
      TX_BUSY   = 1'b0;
      RX_P_Data = 8'h00;
      RX_D_VLD  = 1'b0;

      //          cmd    addr  data   a      b      func  bb  bc  stray nrx rx0    rx1    g0      g1      flen frame          data      err   lat
      vecs[0]  = '{2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, -1, 0, 1'b0, 0, 8'h00, 8'h00, 0,      0,      3, 32'hAA053C00, 16'h0000, 1'b0, 0};
      vecs[1]  = '{2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, -1, 0, 1'b0, 1, 8'h7E, 8'h00, 2,      0,      2, 32'hBB020000, 16'h007E, 1'b0, 0};
      vecs[2]  = '{2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1,  2, 5, 1'b0, 2, 8'h46, 8'h00, 1,      1,      4, 32'hCC123401, 16'h0046, 1'b0, 0};
      vecs[3]  = '{2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, -1, 0, 1'b0, 1, 8'hAB, 8'h00, 0,      0,      2, 32'hDD020000, 16'h00AB, 1'b1, TO-1};
      vecs[4]  = '{2'b00, 4'hF, 8'hFF, 8'h00, 8'h00, 4'h0,  0, 2, 1'b1, 0, 8'h00, 8'h00, 0,      0,      3, 32'hAA0FFF00, 16'h0000, 1'b0, 0};
      vecs[5]  = '{2'b01, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, -1, 0, 1'b1, 1, 8'h5A, 8'h00, 0,      0,      2, 32'hBB000000, 16'h005A, 1'b0, 0};
      vecs[6]  = '{2'b10, 4'h0, 8'h00, 8'hFF, 8'h00, 4'hF,  3, 1, 1'b0, 2, 8'h01, 8'h80, 0,      3,      4, 32'hCCFF000F, 16'h8001, 1'b0, 0};
      vecs[7]  = '{2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF, -1, 0, 1'b0, 2, 8'h11, 8'h22, 1,      0,      2, 32'hDD0F0000, 16'h2211, 1'b0, 0};
      vecs[8]  = '{2'b01, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, -1, 0, 1'b0, 0, 8'h00, 8'h00, 0,      0,      2, 32'hBB090000, 16'h0000, 1'b1, TO-1};
      vecs[9]  = '{2'b01, 4'h6, 8'h00, 8'h00, 8'h00, 4'h0, -1, 0, 1'b0, 1, 8'hC3, 8'h00, TO-2,   0,      2, 32'hBB060000, 16'h00C3, 1'b0, 0};
      vecs[10] = '{2'b10, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3, -1, 0, 1'b0, 2, 8'h34, 8'h12, 0,      TO-2,   4, 32'hCC010203, 16'h1234, 1'b0, 0};
      vecs[11] = '{2'b01, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0, -1, 0, 1'b0, 1, 8'h44, 8'h00, 0,      0,      2, 32'hBB0A0000, 16'h0044, 1'b0, 0};

      @(negedge CLK);
      chk_reset_outputs("reset");
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;

      for (int i = 0; i < 11; i++) run_txn(vecs[i]);

      // Stray byte while idle must be discarded without any pulse.
      @(posedge CLK);
      #1;
      RX_D_VLD  = 1'b1;
      RX_P_Data = 8'h99;
      @(posedge CLK);
      #1;
      RX_D_VLD  = 1'b0;
      @(negedge CLK);
      chk("stray_idle_rdy", {31'd0, REQ_RDY}, 32'd1);
      chk("stray_idle_hold", {16'd0, RSP_DATA}, {16'd0, last_rsp});
      run_txn(vecs[11]);

      // Reset while byte 1 of a write frame is on the wire.
      @(negedge CLK);
      REQ_VLD  = 1'b1;
      REQ_CMD  = 2'b00;
      REQ_ADDR = 4'h3;
      REQ_DATA = 8'h55;
      exp_tx_q.push_back(8'hAA);
      exp_tx_q.push_back(8'h03);
      exp_tx_q.push_back(8'h55);
      @(posedge CLK);
      #1;
      REQ_VLD = 1'b0;
      @(posedge CLK);
      #1;
      chk("rst_pre_byte1", {24'd0, TX_P_Data}, 32'h03);
      RST = 1'b0;
      #1;
      exp_tx_q.delete();
      @(negedge CLK);
      chk_reset_outputs("midrst");
      repeat (2) @(posedge CLK);
      #1;
      RST      = 1'b1;
      last_rsp = 16'h0000;
      run_txn(vecs[0]);

      repeat (3) @(negedge CLK);
      chk("tx_q_empty", exp_tx_q.size(), 32'd0);
      chk("rsp_q_empty", exp_rsp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
